event_count_ctrl: RTL and testbench

Upstream source of the 16-bit `count` value consumed by the three-digit seven-segment scan stage. It accepts three raw push-button inputs (event, run/stop, clear) plus a direction switch, synchronizes them, optionally debounces them, and turns rising edges into single-cycle pulses. A two-state run/stop FSM drives a wrapping up/down counter bounded to 0..CNT_MAX, which the display stage renders directly.

---
 rtl/count_pkg.sv | 17 +
 rtl/key_debounce.sv | 46 ++++
 rtl/event_count_ctrl.sv | 130 +++++++++++++
 tb/tb_event_count_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg
// Shared definitions for the event counter and the seven-segment display
// stage that renders its count.
//   COUNT_W          width of the count bus seen by both blocks
//   CNT_MAX_DEFAULT  default upper bound of the count (three decimal digits)
//   state_t          run/stop FSM state encoding
package count_pkg;

  localparam int COUNT_W         = 16;
  localparam int CNT_MAX_DEFAULT = 999;

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Filters a synchronized push-button level. The output level only changes
// after the input has disagreed with it for long enough; any sample that
// agrees with the current output restarts the wait.
// Only instantiated when EVT_DEBOUNCE_EN is defined.
// Parameters:
//   DB_CYCLES  stable-sample length, >= 2
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   din    in  synchronized raw level
//   dout   out debounced level (reset value 0)
module key_debounce
  import count_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  // The level flips on the edge where the run of differing samples would
  // reach DB_CYCLES-1, so a new level appears DB_CYCLES edges after the
  // raw input was first sampled.
  localparam logic [CW-1:0] FLIP_AT = CW'(DB_CYCLES - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == FLIP_AT) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/event_count_ctrl.sv
// event_count_ctrl
// Turns three raw push buttons and a direction switch into a wrapping
// up/down count in 0..CNT_MAX for the seven-segment scan stage.
// Build option: define EVT_DEBOUNCE_EN to debounce the three keys
// (dir is never debounced).
// Parameters:
//   CNT_MAX    upper count bound, 1..65535
//   DB_CYCLES  debounce stable-sample length (only with EVT_DEBOUNCE_EN)
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   key_evt  in  raw event button, rising edge counts one event
//   key_run  in  raw run/stop button, rising edge toggles run state
//   key_clr  in  raw clear button, rising edge zeroes the count
//   dir      in  1 = count up, 0 = count down
//   count    out current count
//   running  out high while in the RUN state
//   wrap     out one-cycle pulse with the count update that wraps
module event_count_ctrl
  import count_pkg::*;
#(
  parameter int CNT_MAX   = CNT_MAX_DEFAULT,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_evt,
  input  logic               key_run,
  input  logic               key_clr,
  input  logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(CNT_MAX);

  // Bit order for all per-input vectors: {dir, clr, run, evt}.
  logic [3:0] sync_q1, sync_q2;
  logic [2:0] key_lvl, key_lvl_d, key_pulse;
  logic       dir_s, evt_p, run_p, clr_p;
  state_t     state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {dir, key_clr, key_run, key_evt};
      sync_q2 <= sync_q1;
    end
  end

  assign dir_s = sync_q2[3];

`ifdef EVT_DEBOUNCE_EN
  for (genvar i = 0; i < 3; i++) begin : g_db
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sync_q2[i]),
      .dout (key_lvl[i])
    );
  end
`else
  assign key_lvl = sync_q2[2:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_lvl_d <= '0;
    else        key_lvl_d <= key_lvl;
  end

  // A held key yields a single pulse on its rising edge only.
  assign key_pulse = key_lvl & ~key_lvl_d;
  assign evt_p     = key_pulse[0];
  assign run_p     = key_pulse[1];
  assign clr_p     = key_pulse[2];

  always_comb begin
    state_nxt = state;
    if (run_p) begin
      if (state == ST_RUN) state_nxt = ST_STOP;
      else                 state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
    end
  end

  // Events are qualified by the current (pre-toggle) state, and clear
  // overrides any event in the same cycle, including one that would wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        count <= '0;
      end else if (evt_p && state == ST_RUN) begin
        if (dir_s) begin
          if (count == MAX_VAL) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            count <= MAX_VAL;
            wrap  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_event_count_ctrl.sv
// tb_event_count_ctrl
// Directed bench for event_count_ctrl with CNT_MAX = 999. Key presses are
// driven just after a rising edge; outputs are checked between edges.
// Works with or without EVT_DEBOUNCE_EN; the per-cycle reference model is
// only built for the undebounced configuration.
`timescale 1ns/1ps
module tb_event_count_ctrl;

  localparam int CNT_MAX = 999;
  localparam int DB      = 16;
`ifdef EVT_DEBOUNCE_EN
  localparam int LAT      = DB + 1;
  localparam int HOLD     = DB + 4;
  localparam int RST_WAIT = 5;
`else
  localparam int LAT      = 2;
  localparam int HOLD     = 2;
  localparam int RST_WAIT = 1;
`endif
  localparam int GAP = HOLD + 4;

  logic        clk;
  logic        rst_n;
  logic        key_evt, key_run, key_clr, dir;
  logic [15:0] count;
  logic        running, wrap;

  int checks   = 0;
  int failures = 0;
  int wrap_seen = 0;

  event_count_ctrl #(
    .CNT_MAX  (CNT_MAX),
    .DB_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_evt(key_evt),
    .key_run(key_run),
    .key_clr(key_clr),
    .dir    (dir),
    .count  (count),
    .running(running),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count wrap pulses between edges; a one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (rst_n && wrap) wrap_seen++;
  end

`ifndef EVT_DEBOUNCE_EN
  // Reference model: a key whose rising edge is first sampled at edge k acts
  // at edge k+2, using the dir value sampled at edge k. hist[i] holds the
  // {dir, clr, run, evt} samples taken i+1 edges ago.
  logic [3:0] hist [0:2];
  int         m_count;
  logic       m_run, m_wrap;

  always @(posedge clk or negedge rst_n) begin : model
    logic e, r, c, up, n_wrap, n_run;
    int   n_count;
    if (!rst_n) begin
      m_count <= 0;
      m_run   <= 1'b0;
      m_wrap  <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= 4'b0;
    end else begin
      e  = hist[1][0] & ~hist[2][0];
      r  = hist[1][1] & ~hist[2][1];
      c  = hist[1][2] & ~hist[2][2];
      up = hist[1][3];
      n_count = m_count;
      n_wrap  = 1'b0;
      n_run   = m_run;
      if (c) begin
        n_count = 0;
      end else if (e && m_run) begin
        if (up) begin
          if (m_count == CNT_MAX) begin n_count = 0; n_wrap = 1'b1; end
          else n_count = m_count + 1;
        end else begin
          if (m_count == 0) begin n_count = CNT_MAX; n_wrap = 1'b1; end
          else n_count = m_count - 1;
        end
      end
      if (r) n_run = ~m_run;
      m_count <= n_count;
      m_wrap  <= n_wrap;
      m_run   <= n_run;
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= {dir, key_clr, key_run, key_evt};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (count !== 16'(m_count) || running !== m_run || wrap !== m_wrap) begin
        failures++;
        $display("[TB] FAIL cycle-model t=%0t: count=%0d running=%0b wrap=%0b, expected count=%0d running=%0b wrap=%0b",
                 $time, count, running, wrap, m_count, m_run, m_wrap);
      end
    end
  end
`endif

  task automatic checkOutput(input string name, input int exp_count,
                             input logic exp_run, input logic exp_wrap);
    checks++;
    if (count !== 16'(exp_count) || running !== exp_run || wrap !== exp_wrap) begin
      failures++;
      $display("[TB] FAIL %s: count=%0d running=%0b wrap=%0b, expected count=%0d running=%0b wrap=%0b",
               name, count, running, wrap, exp_count, exp_run, exp_wrap);
    end
`ifndef EVT_DEBOUNCE_EN
    if (rst_n) begin
      checks++;
      if (m_count != exp_count || m_run !== exp_run || m_wrap !== exp_wrap) begin
        failures++;
        $display("[TB] FAIL model %s: count=%0d running=%0b wrap=%0b, expected count=%0d running=%0b wrap=%0b",
                 name, m_count, m_run, m_wrap, exp_count, exp_run, exp_wrap);
      end
    end
`endif
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Press the selected keys for 'hold' sampled edges, release, then let the
  // result settle. Ends 1ns after a rising edge.
  task automatic applyStimulus(input logic e, input logic r, input logic c, input int hold);
    @(posedge clk); #1;
    key_evt = e;
    key_run = r;
    key_clr = c;
    repeat (hold) @(posedge clk);
    #1;
    key_evt = 1'b0;
    key_run = 1'b0;
    key_clr = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    rst_n   = 1'b0;
    key_evt = 1'b0;
    key_run = 1'b0;
    key_clr = 1'b0;
    dir     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 1'b1, 1'b0, HOLD);
    checkOutput("run toggle", 0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("five up", 5, 1'b1, 1'b0);
    checkValue("no wrap yet", wrap_seen, 0);

    dir = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("down to zero", 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("wrap down", 999, 1'b1, 1'b0);
    checkValue("wrap count 1", wrap_seen, 1);

    dir = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("wrap up", 0, 1'b1, 1'b0);
    checkValue("wrap count 2", wrap_seen, 2);
    dir = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("wrap down again", 999, 1'b1, 1'b0);
    checkValue("wrap count 3", wrap_seen, 3);

    dir = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("wrap then up", 3, 1'b1, 1'b0);
    checkValue("wrap count 4", wrap_seen, 4);

    applyStimulus(1'b0, 1'b1, 1'b0, HOLD);
    checkOutput("stop", 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("stop ignores evt", 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, HOLD);
    checkOutput("clr in stop", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, HOLD);
    checkOutput("run+evt from stop", 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, HOLD);
    checkOutput("run+evt from run", 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, HOLD);
    applyStimulus(1'b0, 1'b0, 1'b1, HOLD);
    checkOutput("clr in run", 0, 1'b1, 1'b0);

    for (int i = 0; i < 42; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("count 42", 42, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, HOLD);
    checkOutput("clr beats evt", 0, 1'b1, 1'b0);
    dir = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, HOLD);
    checkOutput("clr beats wrap", 0, 1'b1, 1'b0);
    checkValue("wrap count after clr", wrap_seen, 4);
    dir = 1'b1;

    // Latency from first sampled edge k: unchanged at k+LAT-1, updated at k+LAT.
    @(posedge clk); #1;
    key_evt = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1;
    checkOutput("latency before", 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("latency update", 1, 1'b1, 1'b0);
    key_evt = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1000);
    checkOutput("long hold single step", 2, 1'b1, 1'b0);

`ifdef EVT_DEBOUNCE_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("short glitch filtered", 2, 1'b1, 1'b0);
`endif

    applyStimulus(1'b0, 1'b0, 1'b1, HOLD);
    for (int i = 0; i < 123; i++) applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
    checkOutput("count 123", 123, 1'b1, 1'b0);

    // Reset arrives between edges while a press is still in flight.
    @(posedge clk); #1;
    key_evt = 1'b1;
    repeat (RST_WAIT) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 0, 1'b0, 1'b0);
    key_evt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (GAP + LAT) @(posedge clk);
    #1;
    checkOutput("no stale pulse", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
